// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: drains the RX FIFO, filters on destination MAC and length, and hands accepted frames to the host buffer
module rx_frame_ctrl #(
    parameter int BUF_AW  = 11,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [47:0]       mac_addr,
    input  logic              promisc,
    input  logic              fifo_empty,
    output logic              fifo_rden,
    input  logic [7:0]        fifo_dout,
    input  logic              fifo_EOD_out,
    output logic              buf_we,
    output logic [BUF_AW-1:0] buf_addr,
    output logic [7:0]        buf_wdata,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [10:0]       desc_len,
    output logic              desc_bcast,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);
    typedef enum logic [1:0] {RECV, DROP, DESC} state_t;

    localparam logic [BUF_AW:0] CMAX = (BUF_AW+1)'(MAX_LEN);
    localparam logic [BUF_AW:0] CMIN = (BUF_AW+1)'(MIN_LEN);
    localparam logic [BUF_AW:0] C5   = (BUF_AW+1)'(5);
    localparam logic [BUF_AW:0] C6   = (BUF_AW+1)'(6);

    state_t          state, state_n;
    logic            rd_pend;
    logic [BUF_AW:0] cnt, cnt_inc;
    logic            match, bc, match_n, bc_n;
    logic            hdr, at_max, runt, miss;
    logic [7:0]      mac_byte;
    logic            drop_evt, clr;

    // Header byte compare: running address match and broadcast flags over bytes 0..5
    always_comb begin
        cnt_inc  = cnt + 1'b1;
        hdr      = cnt < C6;
        at_max   = cnt == CMAX;
        mac_byte = 8'(mac_addr >> {3'd5 - cnt[2:0], 3'b000});
        match_n  = hdr ? (match && fifo_dout == mac_byte) : match;
        bc_n     = hdr ? (bc && fifo_dout == 8'hFF) : bc;
        runt     = (cnt_inc < CMIN) || (cnt < C5);
        miss     = (cnt == C5) && !(match_n || bc_n || promisc);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= RECV;
        else
            state <= state_n;
    end

    // Next state plus the drop/clear events that accompany each transition
    always_comb begin
        state_n  = state;
        drop_evt = 1'b0;
        clr      = 1'b0;
        if (state == RECV && rd_pend) begin
            if (at_max) begin
                drop_evt = 1'b1;
                clr      = 1'b1;
                state_n  = fifo_EOD_out ? RECV : DROP;
            end else if (fifo_EOD_out) begin
                drop_evt = runt || miss;
                clr      = runt || miss;
                state_n  = (runt || miss) ? RECV : DESC;
            end else if (miss) begin
                drop_evt = 1'b1;
                clr      = 1'b1;
                state_n  = DROP;
            end
        end else if (state == DROP && rd_pend && fifo_EOD_out) begin
            clr     = 1'b1;
            state_n = RECV;
        end else if (state == DESC && desc_ready) begin
            clr     = 1'b1;
            state_n = RECV;
        end
    end

    // Outputs: one read in flight at a time, buffer writes only while receiving
    always_comb begin
        fifo_rden  = (state != DESC) && !fifo_empty && !rd_pend;
        buf_we     = (state == RECV) && rd_pend && !at_max;
        buf_addr   = cnt[BUF_AW-1:0];
        buf_wdata  = buf_we ? fifo_dout : 8'h00;
        desc_valid = state == DESC;
    end

    // Datapath: read tracking, byte count, filter flags, descriptor and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            cnt        <= '0;
            match      <= 1'b1;
            bc         <= 1'b1;
            desc_len   <= '0;
            desc_bcast <= 1'b0;
            frame_cnt  <= '0;
            drop_cnt   <= '0;
        end else begin
            rd_pend <= fifo_rden;
            if (clr) begin
                cnt   <= '0;
                match <= 1'b1;
                bc    <= 1'b1;
            end else if (buf_we) begin
                cnt   <= cnt_inc;
                match <= match_n;
                bc    <= bc_n;
            end
            if (state == RECV && state_n == DESC) begin
                desc_len   <= 11'(cnt_inc);
                desc_bcast <= bc_n;
            end
            if (drop_evt && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
            if (state == DESC && desc_ready && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frame scenarios against rx_frame_ctrl with a behavioural RX FIFO
module tb_rx_frame_ctrl;
    localparam int BUF_AW  = 11;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;
    localparam int DEPTH   = 16384;
    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BAD   = 48'h02_11_22_33_44_56;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic promisc = 1'b0;
    logic stall = 1'b0;
    logic desc_ready = 1'b0;
    logic fifo_empty, fifo_rden, buf_we, desc_valid, desc_bcast;
    logic [7:0] fifo_dout = 8'h00;
    logic fifo_EOD_out = 1'b0;
    logic [BUF_AW-1:0] buf_addr;
    logic [7:0] buf_wdata;
    logic [10:0] desc_len;
    logic [15:0] frame_cnt, drop_cnt;

    int checks = 0;
    int errors = 0;

    logic [8:0] mem [0:DEPTH-1];
    int wp = 0;
    int rp = 0;

    int wr_total = 0, wr_at_max = 0, desc_n = 0, dbl_rd = 0;
    int cyc = 0, last_we_cyc = 0, rise_cyc = 0;
    bit dv_q = 1'b0, rd_q = 1'b0;
    int waddr [0:DEPTH-1];
    int dlen [0:63];
    bit dbc [0:63];

    rx_frame_ctrl #(.BUF_AW(BUF_AW), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .mac_addr(MAC), .promisc(promisc),
        .fifo_empty(fifo_empty), .fifo_rden(fifo_rden), .fifo_dout(fifo_dout),
        .fifo_EOD_out(fifo_EOD_out), .buf_we(buf_we), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_len(desc_len), .desc_bcast(desc_bcast), .frame_cnt(frame_cnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    assign fifo_empty = stall || (rp == wp);

    always @(posedge clk) begin
        if (rst)
            rp <= wp;
        else if (fifo_rden) begin
            fifo_dout    <= mem[rp % DEPTH][7:0];
            fifo_EOD_out <= mem[rp % DEPTH][8];
            rp           <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (buf_we) begin
            waddr[wr_total % DEPTH] = int'(buf_addr);
            wr_total = wr_total + 1;
            last_we_cyc = cyc;
            if (int'(buf_addr) == MAX_LEN) wr_at_max = wr_at_max + 1;
        end
        if (desc_valid && !dv_q) rise_cyc = cyc;
        dv_q = desc_valid;
        if (desc_valid && desc_ready) begin
            dlen[desc_n % 64] = int'(desc_len);
            dbc[desc_n % 64] = desc_bcast;
            desc_n = desc_n + 1;
        end
        if (fifo_rden && rd_q) dbl_rd = dbl_rd + 1;
        rd_q = fifo_rden;
        cyc = cyc + 1;
    end

    task automatic load_frame(input int len, input logic [47:0] dest);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = (i < 6) ? dest[47 - 8*i -: 8] : 8'(i * 7 + 3);
            mem[(wp + i) % DEPTH] = {i == len - 1, b};
        end
        wp = wp + len;
    endtask

    task automatic wait_desc(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = desc_n >= target;
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = rp == wp;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (fifo_rden !== 1'b0) begin errors++; $display("FAIL rst_rden got %b exp 0", fifo_rden); end
        checks++; if (buf_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", buf_we); end
        checks++; if (desc_valid !== 1'b0) begin errors++; $display("FAIL rst_dv got %b exp 0", desc_valid); end
        checks++; if ({desc_len, desc_bcast, buf_addr, buf_wdata} !== '0) begin errors++; $display("FAIL rst_outs got len=%0d bc=%b addr=%0d wd=%0h exp all 0", desc_len, desc_bcast, buf_addr, buf_wdata); end
        checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnts got %0d/%0d exp 0/0", frame_cnt, drop_cnt); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_unicast;
        int w0, d0, bad;
        bit ok;
        w0 = wr_total; d0 = desc_n; bad = 0;
        desc_ready = 1'b1;
        load_frame(64, MAC);
        wait_desc(d0 + 1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL uni_timeout got no descriptor exp one"); end
        checks++; if (wr_total - w0 !== 64) begin errors++; $display("FAIL uni_writes got %0d exp 64", wr_total - w0); end
        for (int i = 0; i < 64; i++) if (waddr[(w0 + i) % DEPTH] != i) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL uni_addrs got %0d bad addresses exp 0", bad); end
        checks++; if (dlen[d0 % 64] !== 64 || dbc[d0 % 64] !== 1'b0) begin errors++; $display("FAIL uni_desc got len=%0d bc=%b exp 64/0", dlen[d0 % 64], dbc[d0 % 64]); end
        checks++; if (rise_cyc - last_we_cyc !== 1) begin errors++; $display("FAIL uni_latency got %0d exp 1", rise_cyc - last_we_cyc); end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd1 || desc_valid !== 1'b0) begin errors++; $display("FAIL uni_fcnt got %0d dv=%b exp 1 dv=0", frame_cnt, desc_valid); end
    endtask

    task automatic test_bcast_hold;
        int d0, bad;
        bit ok;
        d0 = desc_n; bad = 0; ok = 1'b0;
        @(posedge clk); #1;
        desc_ready = 1'b0;
        load_frame(100, BCAST);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = desc_valid;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bc_timeout got no desc_valid exp high"); end
        @(posedge clk); #1;
        load_frame(64, MAC);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!desc_valid || desc_len != 11'd100 || !desc_bcast || fifo_rden) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bc_hold got %0d bad cycles exp 0", bad); end
        checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bc_fcnt_held got %0d exp 1", frame_cnt); end
        @(posedge clk); #1;
        desc_ready = 1'b1;
        wait_desc(d0 + 2, 600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bc_timeout2 got %0d descs exp 2", desc_n - d0); end
        checks++; if (dlen[d0 % 64] !== 100 || dbc[d0 % 64] !== 1'b1) begin errors++; $display("FAIL bc_desc got len=%0d bc=%b exp 100/1", dlen[d0 % 64], dbc[d0 % 64]); end
        checks++; if (dlen[(d0 + 1) % 64] !== 64 || dbc[(d0 + 1) % 64] !== 1'b0) begin errors++; $display("FAIL bc_next got len=%0d bc=%b exp 64/0", dlen[(d0 + 1) % 64], dbc[(d0 + 1) % 64]); end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bc_fcnt got %0d exp 3", frame_cnt); end
    endtask

    task automatic test_mismatch;
        int w0, d0;
        bit ok;
        w0 = wr_total; d0 = desc_n;
        promisc = 1'b0;
        load_frame(80, BAD);
        wait_drain(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mm_timeout got rp=%0d exp wp=%0d", rp, wp); end
        checks++; if (wr_total - w0 !== 6) begin errors++; $display("FAIL mm_writes got %0d exp 6", wr_total - w0); end
        checks++; if (desc_n !== d0) begin errors++; $display("FAIL mm_desc got %0d descs exp 0", desc_n - d0); end
        @(negedge clk);
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL mm_drop got %0d exp 1", drop_cnt); end
        @(posedge clk); #1;
        w0 = wr_total;
        promisc = 1'b1;
        load_frame(80, BAD);
        wait_desc(d0 + 1, 400, ok);
        checks++; if (!ok || dlen[d0 % 64] !== 80) begin errors++; $display("FAIL promisc_len got %0d exp 80", dlen[d0 % 64]); end
        checks++; if (wr_total - w0 !== 80) begin errors++; $display("FAIL promisc_writes got %0d exp 80", wr_total - w0); end
        promisc = 1'b0;
    endtask

    task automatic test_runt;
        int d0;
        bit ok;
        d0 = desc_n;
        load_frame(41, MAC);
        wait_drain(300, ok);
        @(negedge clk);
        checks++; if (drop_cnt !== 16'd2 || desc_n !== d0) begin errors++; $display("FAIL runt41 got drops=%0d descs=%0d exp 2/0", drop_cnt, desc_n - d0); end
        @(posedge clk); #1;
        load_frame(MIN_LEN - 1, MAC);
        wait_drain(300, ok);
        @(negedge clk);
        checks++; if (drop_cnt !== 16'd3 || desc_n !== d0) begin errors++; $display("FAIL runt63 got drops=%0d descs=%0d exp 3/0", drop_cnt, desc_n - d0); end
        @(posedge clk); #1;
        load_frame(3, BAD);
        load_frame(64, MAC);
        wait_desc(d0 + 1, 400, ok);
        @(negedge clk);
        checks++; if (!ok || dlen[d0 % 64] !== 64 || drop_cnt !== 16'd4) begin errors++; $display("FAIL runt3 got len=%0d drops=%0d exp 64/4", dlen[d0 % 64], drop_cnt); end
        checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL runt_fcnt got %0d exp 5", frame_cnt); end
    endtask

    task automatic test_oversize;
        int w0, d0;
        bit ok;
        w0 = wr_total; d0 = desc_n;
        load_frame(MAX_LEN + 10, MAC);
        wait_drain(4000, ok);
        @(negedge clk);
        checks++; if (!ok || drop_cnt !== 16'd5) begin errors++; $display("FAIL ovr_drop got %0d exp 5", drop_cnt); end
        checks++; if (wr_total - w0 !== MAX_LEN || wr_at_max !== 0) begin errors++; $display("FAIL ovr_writes got %0d at_max=%0d exp %0d/0", wr_total - w0, wr_at_max, MAX_LEN); end
        @(posedge clk); #1;
        w0 = wr_total;
        load_frame(MAX_LEN + 1, MAC);
        wait_drain(4000, ok);
        @(negedge clk);
        checks++; if (!ok || drop_cnt !== 16'd6 || desc_n !== d0) begin errors++; $display("FAIL ovr_eod_max got drops=%0d descs=%0d exp 6/0", drop_cnt, desc_n - d0); end
        checks++; if (wr_total - w0 !== MAX_LEN || wr_at_max !== 0) begin errors++; $display("FAIL ovr_eod_writes got %0d at_max=%0d exp %0d/0", wr_total - w0, wr_at_max, MAX_LEN); end
        @(posedge clk); #1;
        load_frame(MAX_LEN, MAC);
        load_frame(64, MAC);
        wait_desc(d0 + 2, 4000, ok);
        checks++; if (!ok || dlen[d0 % 64] !== MAX_LEN || dlen[(d0 + 1) % 64] !== 64) begin errors++; $display("FAIL ovr_after got %0d,%0d exp %0d,64", dlen[d0 % 64], dlen[(d0 + 1) % 64], MAX_LEN); end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd7 || drop_cnt !== 16'd6) begin errors++; $display("FAIL ovr_cnts got %0d/%0d exp 7/6", frame_cnt, drop_cnt); end
    endtask

    task automatic test_back_to_back;
        int d0;
        bit ok;
        d0 = desc_n; ok = 1'b0;
        load_frame(64, MAC);
        load_frame(70, MAC);
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            stall = 1'($urandom_range(0, 1));
            ok = desc_n >= d0 + 2;
        end
        stall = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout got %0d descs exp 2", desc_n - d0); end
        checks++; if (dlen[d0 % 64] !== 64 || dlen[(d0 + 1) % 64] !== 70) begin errors++; $display("FAIL b2b_order got %0d,%0d exp 64,70", dlen[d0 % 64], dlen[(d0 + 1) % 64]); end
        checks++; if (dbl_rd !== 0) begin errors++; $display("FAIL b2b_outstanding got %0d double reads exp 0", dbl_rd); end
        @(negedge clk);
        checks++; if (frame_cnt !== 16'd9) begin errors++; $display("FAIL b2b_fcnt got %0d exp 9", frame_cnt); end
    endtask

    task automatic test_rst_mid;
        int w0, d0;
        bit ok;
        w0 = wr_total; d0 = desc_n; ok = 1'b0;
        load_frame(64, MAC);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk); #1;
            ok = wr_total - w0 >= 31;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstm_timeout got %0d writes exp 31", wr_total - w0); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({fifo_rden, buf_we, desc_valid, buf_addr} !== '0) begin errors++; $display("FAIL rstm_outs got rden=%b we=%b dv=%b addr=%0d exp 0", fifo_rden, buf_we, desc_valid, buf_addr); end
        checks++; if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0 || desc_len !== 11'd0) begin errors++; $display("FAIL rstm_regs got %0d/%0d/%0d exp 0/0/0", frame_cnt, drop_cnt, desc_len); end
        @(posedge clk); #1;
        d0 = desc_n;
        load_frame(64, MAC);
        wait_desc(d0 + 1, 400, ok);
        @(negedge clk);
        checks++; if (!ok || dlen[d0 % 64] !== 64) begin errors++; $display("FAIL rstm_len got %0d exp 64", dlen[d0 % 64]); end
        checks++; if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rstm_cnts got %0d/%0d exp 1/0", frame_cnt, drop_cnt); end
    endtask

    initial begin
        test_reset;
        test_unicast;
        test_bcast_hold;
        test_mismatch;
        test_runt;
        test_oversize;
        test_back_to_back;
        test_rst_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
